prng_arbiter: RTL and testbench
===============================

// Module: prng_arbiter
// PURPOSE
// - Shares one 32-bit Galois LFSR pseudorandom source between NREQ user-project requesters (LED effect engines).
// - Sequences the source: round-robin grant, advance LFSR cfg_steps shifts, deliver one WIDTH-bit word per draw.
// - Configured by Wishbone-mapped registers upstream (enable, seed, step count); sits between those regs and effect engines.
// PARAMETERS
// - NREQ    4   number of requesters (2..8)
// - WIDTH   16  delivered word width (<=32), rsp_data = lfsr[WIDTH-1:0]
// - STEP_W  4   width of cfg_steps
// PORTS
// - clk            in   1       system clock
// - rst_n          in   1       reset, asynchronous assert, active-low
// - cfg_enable     in   1       1 = new grants allowed
// - cfg_seed       in   32      seed value
// - cfg_seed_load  in   1       single-cycle pulse: load cfg_seed
// - cfg_steps      in   STEP_W  LFSR shifts per draw; 0 treated as 1
// - req            in   NREQ    request level per requester, held until its rsp handshake
// - rsp_ready      in   NREQ    requester accepts rsp_data
// - rsp_valid      out  NREQ    one-hot, data valid for that requester
// - rsp_data       out  WIDTH   shared response bus
// - busy           out  1       FSM not in IDLE
// - stat_draws     out  16      completed draws, wraps 0xFFFF->0
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (rst_n).
// - Reset: lfsr=32'h0000_0001, rr pointer=NREQ-1, state=IDLE, rsp_valid=0, rsp_data=0, busy=0, stat_draws=0.
// - LFSR step: lsb=1 -> s=(s>>1)^32'h8020_0003, else s=s>>1 (x^32+x^22+x^2+x+1).
// - FSM IDLE: if cfg_enable && |req -> grant first set req at index (ptr+1) mod NREQ upward; ptr<=grant;
//   cnt<=max(cfg_steps,1); -> STEP.
// - STEP: one LFSR shift per cycle, cnt--; on last shift register rsp_data from the shifted value -> DELIVER.
// - DELIVER: rsp_valid[grant]=1, rsp_data stable; on rsp_ready[grant] -> IDLE, stat_draws++, rsp_valid cleared next cycle.
// - Latency: req first seen in IDLE at cycle t -> rsp_valid high at cycle t+1+steps. Min draw period steps+2 with rsp_ready tied high.
// - cfg_steps sampled only at grant; changes mid-draw ignored.
// - cfg_enable low: no new grants; draw in STEP/DELIVER completes normally.
// - req[grant] dropped in STEP/DELIVER: draw completes, rsp_valid stays until rsp_ready (no silent abort).
// - cfg_seed_load: highest priority, any state: lfsr<=cfg_seed (32'h0 replaced by 32'h1);
//   current draw aborted, state=IDLE, rsp_valid=0, stat_draws unchanged, ptr unchanged.
//   Aborted requester is re-arbitrated normally.
// - Seed load and rsp_ready in the same cycle: seed load wins, draw not counted.
// - rsp_ready on non-granted index: ignored.
// STRUCTURE
// - prng_pkg: POLY=32'h8020_0003, SEED_DEFAULT=32'h1, state enum {IDLE,STEP,DELIVER}.
// - Sub-module prng_lfsr: 32-bit register, load/seed-zero guard, step enable, async rst_n.
// - Top holds FSM, round-robin pointer, step counter, output regs.
// TESTING
// - Reset, then seed 1, steps 1, req=4'b0001 -> rsp_valid=4'b0001 after 2 cycles, rsp_data=16'h0003; next draw 16'h0002.
// - req=4'b1111 held, rsp_ready tied high -> grant order 0,1,2,3,0.
//   stat_draws=5 after 5 draws; one draw every steps+2 cycles.
// - Seed load 32'h0 -> lfsr=32'h1; first draw with steps 2 -> rsp_data=16'h0002.
// - cfg_seed_load pulse during STEP with steps 8 -> rsp_valid never rises, busy=0 next cycle.
//   Requester re-granted, stat_draws unchanged.
// - rsp_ready held low 10 cycles in DELIVER -> rsp_valid/rsp_data stable, no other grant, lfsr frozen.
// - cfg_enable low with req active -> busy=0, no grant; mid-draw drop of enable -> draw completes, then idle.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg: shared constants, FSM state type and LFSR step function for the PRNG arbiter
package prng_pkg;
  localparam logic [31:0] POLY         = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT = 32'h0000_0001;
  typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_e;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction
endpackage

// File: rtl/prng_lfsr.sv
// prng_lfsr: 32-bit Galois LFSR with seed load (zero seed forced to 1) and step enable
module prng_lfsr import prng_pkg::*; #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [31:0]      seed_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] next_o
);
  logic [31:0] lfsr_q, lfsr_d, nxt;
  assign nxt    = lfsr_next(lfsr_q);
  assign next_o = nxt[OUT_W-1:0];
  // Load beats step; an all-zero seed would lock the LFSR so it becomes 1
  always_comb lfsr_d = load_i ? ((seed_i == '0) ? SEED_DEFAULT : seed_i) : step_i ? nxt : lfsr_q;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED_DEFAULT;
    else        lfsr_q <= lfsr_d;
endmodule

// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of one LFSR source among NREQ requesters
module prng_arbiter import prng_pkg::*; #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic [31:0]       cfg_seed,
  input  logic              cfg_seed_load,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              busy,
  output logic [15:0]       stat_draws
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_e            state_q;
  logic [PW-1:0]     ptr_q, grant_d;
  logic [STEP_W-1:0] cnt_q, steps_eff;
  logic [WIDTH-1:0]  data_q, lfsr_nx;
  logic [NREQ-1:0]   valid_q;
  logic [15:0]       draws_q;
  assign steps_eff  = (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
  assign rsp_valid  = valid_q;
  assign rsp_data   = data_q;
  assign stat_draws = draws_q;
  assign busy       = state_q != IDLE;
  prng_lfsr #(.OUT_W(WIDTH)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cfg_seed_load),
    .seed_i (cfg_seed),
    .step_i ((state_q == STEP) && !cfg_seed_load),
    .next_o (lfsr_nx)
  );
  // Round-robin pick: scan downward so the nearest set request after ptr wins
  always_comb begin
    grant_d = ptr_q;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) grant_d = PW'((int'(ptr_q) + k) % NREQ);
  end
  // Draw sequencer; seed load aborts any draw without touching ptr or count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      draws_q <= '0;
    end else if (cfg_seed_load) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (cfg_enable && |req) begin
            ptr_q   <= grant_d;
            cnt_q   <= steps_eff;
            state_q <= STEP;
          end
        STEP: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == STEP_W'(1)) begin
            data_q  <= lfsr_nx;
            valid_q <= NREQ'(1) << ptr_q;
            state_q <= DELIVER;
          end
        end
        DELIVER:
          if (rsp_ready[ptr_q]) begin
            valid_q <= '0;
            draws_q <= draws_q + 1'b1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: table vectors, directed corner sequences and a randomized transaction model
module tb_prng_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, cfg_enable = 1'b0, cfg_seed_load = 1'b0, busy;
  logic [31:0] cfg_seed = '0;
  logic [3:0]  cfg_steps = '0, req = '0, rsp_ready = '0, rsp_valid, mask = 4'h1;
  logic [15:0] rsp_data, stat_draws;
  int applied = 0, miscompares = 0;
  logic [31:0] m_lfsr = 32'h1;
  int m_ptr = 3, m_draws = 0, m_idx = 0, m_eff = 0, m_wait = 0;
  logic m_pend = 1'b0, m_deliv = 1'b0;
  logic [15:0] m_exp_data = '0;
  always #5 clk = ~clk;
  prng_arbiter #(.NREQ(4), .WIDTH(16), .STEP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_seed(cfg_seed),
    .cfg_seed_load(cfg_seed_load), .cfg_steps(cfg_steps), .req(req), .rsp_ready(rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .stat_draws(stat_draws)
  );
  typedef struct {
    logic [31:0] seed;
    logic [3:0]  steps;
    logic [3:0]  rq;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;
  } vec_t;
  vec_t tbl[8];
  function automatic logic [31:0] adv(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction
  function automatic int eff(input logic [3:0] st);
    return (st == 4'd0) ? 1 : int'(st);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      tick;
      n++;
    end
  endtask
  task automatic do_cycle(input logic en, input logic [3:0] rdy);
    logic [3:0] st;
    logic hs;
    st = 4'($urandom_range(0, 15));
    cfg_steps = st;
    cfg_enable = en;
    rsp_ready = rdy;
    req = mask;
    hs = m_deliv && rdy[m_idx];
    tick;
    if (hs) begin
      m_draws++;
      m_deliv = 1'b0;
      chk("rnd_draws", stat_draws, m_draws);
      chk("rnd_clear", rsp_valid, 0);
    end else if (m_deliv) begin
      chk("rnd_hold_valid", rsp_valid, 1 << m_idx);
      chk("rnd_hold_data", rsp_data, m_exp_data);
    end else if (m_pend) begin
      m_wait++;
      chk("rnd_busy", busy, 1);
      if (m_wait >= m_eff) begin
        chk("rnd_valid", rsp_valid, 1 << m_idx);
        chk("rnd_data", rsp_data, m_exp_data);
        m_pend = 1'b0;
        m_deliv = 1'b1;
      end else chk("rnd_early", rsp_valid, 0);
    end else if (en) begin
      for (int k = 1; k <= 4; k++)
        if (mask[(m_ptr + k) % 4]) begin
          m_idx = (m_ptr + k) % 4;
          break;
        end
      m_ptr = m_idx;
      m_eff = eff(st);
      m_lfsr = adv(m_lfsr, m_eff);
      m_exp_data = m_lfsr[15:0];
      m_wait = 0;
      m_pend = 1'b1;
      chk("rnd_grant", busy, 1);
    end else chk("rnd_no_grant", busy, 0);
  endtask
  initial begin
    int n;
    int tt[5];
    logic [3:0] vv[5];
    logic [15:0] dd[5], rr_data[5], held;
    tbl[0] = '{32'h0000_0001, 4'd1, 4'b0001, 4'b0001, 16'h0003};
    tbl[1] = '{32'h0000_0000, 4'd2, 4'b0001, 4'b0001, 16'h0002};
    tbl[2] = '{32'h0000_0001, 4'd0, 4'b0010, 4'b0010, 16'h0003};
    tbl[3] = '{32'h0000_0001, 4'd3, 4'b1111, 4'b0100, 16'h0001};
    tbl[4] = '{32'h0000_0001, 4'd4, 4'b1001, 4'b1000, 16'h0003};
    tbl[5] = '{32'h0000_0001, 4'd5, 4'b0110, 4'b0010, 16'h0002};
    tbl[6] = '{32'h1234_5678, 4'd1, 4'b0101, 4'b0100, 16'h2B3C};
    tbl[7] = '{32'hFFFF_FFFF, 4'd1, 4'b1000, 4'b1000, 16'hFFFC};
    rr_data = '{16'h0003, 16'h0002, 16'h0001, 16'h0003, 16'h0002};
    tick;
    tick;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_draws", stat_draws, 0);
    rst_n = 1'b1;
    cfg_steps = 4'd1;
    req = 4'b1111;
    rsp_ready = 4'b1111;
    cfg_enable = 1'b1;
    n = 0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      tick;
      if (rsp_valid != '0) begin
        vv[n] = rsp_valid;
        dd[n] = rsp_data;
        tt[n] = c;
        n++;
        if (n == 5) cfg_enable = 1'b0;
      end
    end
    chk("rr_count", n, 5);
    chk("rr_first_lat", tt[0], 2);
    for (int i = 0; i < n; i++) begin
      chk("rr_order", vv[i], 1 << (i % 4));
      chk("rr_data", dd[i], rr_data[i]);
      if (i > 0) chk("rr_period", tt[i] - tt[i-1], 3);
    end
    tick;
    rsp_ready = '0;
    req = '0;
    chk("rr_draws", stat_draws, 5);
    chk("rr_idle", busy, 0);
    m_ptr = 0;
    m_draws = 5;
    for (int e = 0; e < 8; e++) begin
      cfg_enable = 1'b0;
      cfg_seed = tbl[e].seed;
      cfg_seed_load = 1'b1;
      tick;
      cfg_seed_load = 1'b0;
      cfg_steps = tbl[e].steps;
      req = tbl[e].rq;
      cfg_enable = 1'b1;
      wait_valid(n);
      chk("tbl_latency", n, eff(tbl[e].steps) + 1);
      chk("tbl_valid", rsp_valid, tbl[e].exp_valid);
      chk("tbl_data", rsp_data, tbl[e].exp_data);
      rsp_ready = tbl[e].exp_valid;
      cfg_enable = 1'b0;
      tick;
      rsp_ready = '0;
      req = '0;
      m_draws++;
      chk("tbl_draws", stat_draws, m_draws);
      chk("tbl_clear", rsp_valid, 0);
      chk("tbl_idle", busy, 0);
    end
    cfg_seed = '0;
    cfg_seed_load = 1'b1;
    tick;
    cfg_seed_load = 1'b0;
    m_lfsr = 32'h1;
    cfg_steps = 4'd8;
    req = 4'b0001;
    cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_pre_valid", rsp_valid, 0);
    end
    chk("abort_pre_busy", busy, 1);
    cfg_seed = 32'h0;
    cfg_seed_load = 1'b1;
    tick;
    cfg_seed_load = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_draws", stat_draws, m_draws);
    wait_valid(n);
    m_lfsr = adv(m_lfsr, 8);
    chk("abort_regrant_lat", n, 9);
    chk("abort_regrant_valid", rsp_valid, 4'b0001);
    chk("abort_regrant_data", rsp_data, m_lfsr[15:0]);
    rsp_ready = 4'b0001;
    cfg_enable = 1'b0;
    tick;
    rsp_ready = '0;
    req = '0;
    m_draws++;
    chk("abort_draws_after", stat_draws, m_draws);
    cfg_steps = 4'd2;
    req = 4'b0010;
    cfg_enable = 1'b1;
    wait_valid(n);
    m_lfsr = adv(m_lfsr, 2);
    chk("hold_valid0", rsp_valid, 4'b0010);
    chk("hold_data0", rsp_data, m_lfsr[15:0]);
    held = rsp_data;
    req = 4'b1111;
    rsp_ready = 4'b1101;
    cfg_steps = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_valid", rsp_valid, 4'b0010);
      chk("hold_data", rsp_data, held);
      chk("hold_draws", stat_draws, m_draws);
    end
    rsp_ready = 4'b0010;
    tick;
    rsp_ready = '0;
    m_draws++;
    chk("hold_draws_after", stat_draws, m_draws);
    chk("hold_clear", rsp_valid, 0);
    wait_valid(n);
    m_lfsr = adv(m_lfsr, 1);
    chk("frozen_valid", rsp_valid, 4'b0100);
    chk("frozen_data", rsp_data, m_lfsr[15:0]);
    cfg_enable = 1'b0;
    rsp_ready = 4'b0100;
    tick;
    rsp_ready = '0;
    m_draws++;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("dis_busy", busy, 0);
      chk("dis_valid", rsp_valid, 0);
    end
    cfg_steps = 4'd3;
    cfg_enable = 1'b1;
    tick;
    cfg_enable = 1'b0;
    chk("dis_mid_busy", busy, 1);
    wait_valid(n);
    m_lfsr = adv(m_lfsr, 3);
    chk("dis_mid_lat", n, 3);
    chk("dis_mid_valid", rsp_valid, 4'b1000);
    chk("dis_mid_data", rsp_data, m_lfsr[15:0]);
    rsp_ready = 4'b1000;
    tick;
    rsp_ready = '0;
    m_draws++;
    chk("dis_mid_draws", stat_draws, m_draws);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("dis_after_busy", busy, 0);
    end
    req = 4'b0001;
    cfg_enable = 1'b1;
    tick;
    req = '0;
    cfg_enable = 1'b0;
    wait_valid(n);
    m_lfsr = adv(m_lfsr, 3);
    chk("drop_lat", n, 3);
    chk("drop_data", rsp_data, m_lfsr[15:0]);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("drop_valid", rsp_valid, 4'b0001);
    end
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = '0;
    m_draws++;
    chk("drop_draws", stat_draws, m_draws);
    chk("drop_clear", rsp_valid, 0);
    m_ptr = 0;
    for (int c = 0; c < 6; c++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 150; i++) do_cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      for (int i = 0; i < 40 && (m_pend || m_deliv); i++) do_cycle(1'b0, 4'hF);
      chk("rnd_drain", {m_pend, m_deliv}, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
